// File: rtl/stb_pkg.sv
// Shared types for the store buffer: data_mem access modes, entry layout and access sizing.
package stb_pkg;

  localparam int STB_ADDR_W = 32;
  localparam int STB_DATA_W = 32;

  typedef enum logic [2:0] {
    MODE_BYTE   = 3'b000,
    MODE_HALF   = 3'b001,
    MODE_WORD   = 3'b010,
    MODE_BYTE_U = 3'b011,
    MODE_HALF_U = 3'b100
  } mem_mode_e;

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    mem_mode_e             mode;
  } stb_entry_t;

  function automatic logic [2:0] acc_size(input logic [2:0] mode);
    case (mode)
      MODE_BYTE, MODE_BYTE_U: acc_size = 3'd1;
      MODE_HALF, MODE_HALF_U: acc_size = 3'd2;
      MODE_WORD:              acc_size = 3'd4;
      default:                acc_size = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/stb_overlap_chk.sv
// Byte-range overlap comparator between one buffered store and the current load.
module stb_overlap_chk
  import stb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [2:0]        st_mode_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [2:0]        ld_mode_i,
  output logic              overlap_o
);

  // One extra bit keeps a range ending past the top address from wrapping to zero.
  logic [ADDR_W:0] st_lo, st_hi, ld_lo, ld_hi;

  assign st_lo = {1'b0, st_addr_i};
  assign ld_lo = {1'b0, ld_addr_i};
  assign st_hi = st_lo + {{(ADDR_W-2){1'b0}}, acc_size(st_mode_i)} - (ADDR_W+1)'(1);
  assign ld_hi = ld_lo + {{(ADDR_W-2){1'b0}}, acc_size(ld_mode_i)} - (ADDR_W+1)'(1);

  assign overlap_o = (st_lo <= ld_hi) && (ld_lo <= st_hi);

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores in front of data_mem; loads win the port, overlapping loads stall.
// Optional macro STB_PERF_EN adds a saturating 16-bit stalled-load cycle counter output.
module store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_mode,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_mode,
  output logic              ld_stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_acc_mode,
  output logic [31:0]       mem_wdata,
  output logic              empty
`ifdef STB_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  stb_entry_t       entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic             ld_go;
  logic             st_storable;
  logic [DEPTH-1:0] hit;
  stb_entry_t       head;

  assign head        = entry_q[rd_ptr_q];
  assign st_ready    = (count_q != CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign st_storable = (st_mode == MODE_BYTE) || (st_mode == MODE_HALF) || (st_mode == MODE_WORD);
  // Unsigned-mode stores complete the handshake but are dropped.
  assign push        = st_valid && st_ready && st_storable;

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    stb_overlap_chk #(
      .ADDR_W(ADDR_W)
    ) u_chk (
      .st_addr_i(ADDR_W'(entry_q[i].addr)),
      .st_mode_i(entry_q[i].mode),
      .ld_addr_i(ld_addr),
      .ld_mode_i(ld_mode),
      .overlap_o(hit[i])
    );
  end

  assign ld_stall = ld_en && |(hit & valid_q);
  assign ld_go    = rst_n && ld_en && !ld_stall;

  always_comb begin
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_acc_mode = '0;
    mem_wdata    = '0;
    pop          = 1'b0;
    if (ld_go) begin
      mem_rd_en    = 1'b1;
      mem_addr     = ld_addr;
      mem_acc_mode = ld_mode;
    end else if (count_q != '0) begin
      mem_wr_en    = 1'b1;
      mem_addr     = ADDR_W'(head.addr);
      mem_acc_mode = head.mode;
      mem_wdata    = head.data;
      pop          = 1'b1;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: valid_q and count_q gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[wr_ptr_q] <= '{addr: STB_ADDR_W'(st_addr),
                             data: st_data,
                             mode: mem_mode_e'(st_mode)};
    end
  end

`ifdef STB_PERF_EN
  logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (ld_stall && (perf_stall_cnt_q != 16'hFFFF)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_ld_st_same_cycle : assert property (@(posedge clk) disable iff (!rst_n) !(st_valid && ld_en))
    else $warning("store_buffer: st_valid and ld_en asserted in the same cycle");
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected drains are queued at push time and checked as they appear.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_mode = '0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_mode = '0;
  logic        ld_stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_acc_mode;
  logic [31:0] mem_wdata;
  logic        empty;
`ifdef STB_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_mode(ld_mode), .ld_stall(ld_stall),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_acc_mode(mem_acc_mode), .mem_wdata(mem_wdata), .empty(empty)
`ifdef STB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drain scoreboard: every write to data_mem must match the oldest outstanding store.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL drain_spurious: write addr=%h data=%h with no store pending", mem_addr, mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        if ({mem_addr, mem_wdata, mem_acc_mode} !== {mon_e.addr, mon_e.data, mon_e.mode}) begin
          errors++;
          $display("FAIL drain_order: got addr=%h data=%h mode=%b, required addr=%h data=%h mode=%b",
                   mem_addr, mem_wdata, mem_acc_mode, mon_e.addr, mon_e.data, mon_e.mode);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m, input bit expect_acc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mode  = m;
    if (expect_acc && (m <= 3'b010)) sb_q.push_back('{addr: a, data: d, mode: m});
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0;
    ld_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 32'h44;
    #12;
    @(negedge clk);
    checks++;
    if ({st_ready, empty, ld_stall, mem_rd_en, mem_wr_en} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: rdy/empty/stall/rd/wr=%b required 11000",
               {st_ready, empty, ld_stall, mem_rd_en, mem_wr_en});
    end
    checks++;
    if ({mem_addr, mem_acc_mode, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h mode=%b wdata=%h required all 0", mem_addr, mem_acc_mode, mem_wdata);
    end
`ifdef STB_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf: %0d required 0", perf_stall_cnt);
    end
`endif
    tick();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_push();
    tick();
    drive_store(32'h10, 32'hAABBCCDD, 3'b010, 1'b1);
    @(negedge clk);
    checks++;
    if ({st_ready, mem_wr_en, empty} !== 3'b101) begin
      errors++;
      $display("FAIL push_no_bypass: ready/wr/empty=%b required 101", {st_ready, mem_wr_en, empty});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_wr_en, mem_addr, mem_acc_mode, mem_wdata, empty} !== {1'b1, 32'h10, 3'b010, 32'hAABBCCDD, 1'b0}) begin
      errors++;
      $display("FAIL push_drain: wr=%b addr=%h mode=%b wdata=%h empty=%b required 1 10 010 aabbccdd 0",
               mem_wr_en, mem_addr, mem_acc_mode, mem_wdata, empty);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({empty, mem_wr_en} !== 2'b10) begin
      errors++;
      $display("FAIL push_empty_after: empty/wr=%b required 10", {empty, mem_wr_en});
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_store(32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 3'b010, 1'b1);
      ld_en   = 1'b1;
      ld_addr = 32'h80;
      ld_mode = 3'b010;
      @(negedge clk);
      checks++;
      if ({st_ready, mem_rd_en, mem_wr_en, ld_stall, mem_addr} !== {4'b1100, 32'h80}) begin
        errors++;
        $display("FAIL full_fill%0d: ready/rd/wr/stall=%b addr=%h required 1100 80", k,
                 {st_ready, mem_rd_en, mem_wr_en, ld_stall}, mem_addr);
      end
    end
    tick();
    drive_store(32'h200, 32'hDEADBEEF, 3'b010, 1'b0);
    @(negedge clk);
    checks++;
    if ({st_ready, empty} !== 2'b00) begin
      errors++;
      $display("FAIL full_refuse: ready/empty=%b required 00", {st_ready, empty});
    end
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b1) begin
        errors++;
        $display("FAIL full_drain%0d: wr=%b required 1", k, mem_wr_en);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({empty, st_ready} !== 2'b11) begin
      errors++;
      $display("FAIL full_drained: empty/ready=%b required 11", {empty, st_ready});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_store(32'h300 + 32'(k), 32'h11 * 32'(k + 1), 3'b000, 1'b1);
      @(negedge clk);
      checks++;
      if ({mem_wr_en, empty} !== ((k == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: wr/empty=%b required %b", k, {mem_wr_en, empty},
                 (k == 0) ? 2'b01 : 2'b10);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_wr_en, mem_addr} !== {1'b1, 32'h302}) begin
      errors++;
      $display("FAIL b2b_last: wr=%b addr=%h required 1 302", mem_wr_en, mem_addr);
    end
    tick();
  endtask

  task automatic test_stall();
    tick();
    drive_store(32'h21, 32'h00001234, 3'b001, 1'b1);
    tick();
    idle_inputs();
    ld_en   = 1'b1;
    ld_addr = 32'h22;
    ld_mode = 3'b000;
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_wr_en, mem_rd_en, mem_addr} !== {3'b110, 32'h21}) begin
      errors++;
      $display("FAIL stall_overlap: stall/wr/rd=%b addr=%h required 110 21",
               {ld_stall, mem_wr_en, mem_rd_en}, mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_rd_en, mem_wr_en, mem_addr, mem_acc_mode} !== {3'b010, 32'h22, 3'b000}) begin
      errors++;
      $display("FAIL stall_release: stall/rd/wr=%b addr=%h mode=%b required 010 22 000",
               {ld_stall, mem_rd_en, mem_wr_en}, mem_addr, mem_acc_mode);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_no_overlap();
    tick();
    drive_store(32'h23, 32'h0000005A, 3'b000, 1'b1);
    tick();
    idle_inputs();
    ld_en   = 1'b1;
    ld_addr = 32'h24;
    ld_mode = 3'b001;
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_rd_en, mem_wr_en, mem_addr, mem_acc_mode} !== {3'b010, 32'h24, 3'b001}) begin
      errors++;
      $display("FAIL nolap_load: stall/rd/wr=%b addr=%h mode=%b required 010 24 001",
               {ld_stall, mem_rd_en, mem_wr_en}, mem_addr, mem_acc_mode);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 32'h23, 32'h5A}) begin
      errors++;
      $display("FAIL nolap_drain: wr=%b addr=%h wdata=%h required 1 23 5a", mem_wr_en, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_addr_top();
    tick();
    drive_store(32'hFFFFFFFE, 32'h01020304, 3'b010, 1'b1);
    tick();
    idle_inputs();
    ld_en   = 1'b1;
    ld_addr = 32'h0;
    ld_mode = 3'b000;
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_rd_en} !== 2'b01) begin
      errors++;
      $display("FAIL top_nowrap: stall/rd=%b required 01", {ld_stall, mem_rd_en});
    end
    tick();
    ld_addr = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_wr_en} !== 2'b11) begin
      errors++;
      $display("FAIL top_overlap: stall/wr=%b required 11", {ld_stall, mem_wr_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({ld_stall, mem_rd_en, mem_addr} !== {2'b01, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL top_release: stall/rd=%b addr=%h required 01 ffffffff", {ld_stall, mem_rd_en}, mem_addr);
    end
    tick();
    idle_inputs();
`ifdef STB_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL perf_count: %0d required 2", perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_unsigned_mode();
    for (int k = 0; k < 2; k++) begin
      tick();
      drive_store(32'h30, 32'hFFFF8001, (k == 0) ? 3'b011 : 3'b100, 1'b1);
      @(negedge clk);
      checks++;
      if ({st_ready, empty} !== 2'b11) begin
        errors++;
        $display("FAIL umode_handshake%0d: ready/empty=%b required 11", k, {st_ready, empty});
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({empty, mem_wr_en} !== 2'b10) begin
        errors++;
        $display("FAIL umode_dropped%0d: empty/wr=%b required 10", k, {empty, mem_wr_en});
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_store(32'h400 + 32'(4 * k), 32'h5A5A0000 + 32'(k), 3'b010, 1'b1);
      ld_en   = 1'b1;
      ld_addr = 32'h80;
      ld_mode = 3'b010;
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending: empty=%b required 0", empty);
    end
    #1;
    rst_n = 1'b0;
    ld_en = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if ({empty, mem_wr_en, st_ready, mem_rd_en} !== 4'b1010) begin
      errors++;
      $display("FAIL rstmid_clear: empty/wr/ready/rd=%b required 1010", {empty, mem_wr_en, st_ready, mem_rd_en});
    end
`ifdef STB_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_perf: %0d required 0", perf_stall_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({empty, mem_wr_en} !== 2'b10) begin
        errors++;
        $display("FAIL rstmid_after%0d: empty/wr=%b required 10", k, {empty, mem_wr_en});
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_push();
    test_full();
    test_back_to_back();
    test_stall();
    test_no_overlap();
    test_addr_top();
    test_unsigned_mode();
    test_reset_mid();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d stores never drained, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
